// File: rtl/biriscv_csr_wb_if.sv
// ============================================================================
// Module      : biriscv_csr_wb_if
// Description : CSR writeback bus from the CSR writeback stage to the CSR
//               register file. It carries the commit of a CSR write, the
//               committed exception code, the faulting PC and the xtval value.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals
//   csr_writeback_write_o          1   commit CSR write
//   csr_writeback_waddr_o          12  CSR address (opcode[31:20])
//   csr_writeback_wdata_o          32  CSR write data
//   csr_writeback_exception_o      6   committed exception code (0 = none)
//   csr_writeback_exception_pc_o   32  PC of the committed instruction
//   csr_writeback_exception_addr_o 32  xtval value
// Modports
//   master : driven by biriscv_csr_wb
//   slave  : consumed by the CSR register file
// ============================================================================
`default_nettype none

interface biriscv_csr_wb_if;
  logic        csr_writeback_write_o;
  logic [11:0] csr_writeback_waddr_o;
  logic [31:0] csr_writeback_wdata_o;
  logic [5:0]  csr_writeback_exception_o;
  logic [31:0] csr_writeback_exception_pc_o;
  logic [31:0] csr_writeback_exception_addr_o;

  modport master (
    output csr_writeback_write_o,
    output csr_writeback_waddr_o,
    output csr_writeback_wdata_o,
    output csr_writeback_exception_o,
    output csr_writeback_exception_pc_o,
    output csr_writeback_exception_addr_o
  );

  modport slave (
    input  csr_writeback_write_o,
    input  csr_writeback_waddr_o,
    input  csr_writeback_wdata_o,
    input  csr_writeback_exception_o,
    input  csr_writeback_exception_pc_o,
    input  csr_writeback_exception_addr_o
  );
endinterface

`default_nettype wire

// File: rtl/biriscv_csr_wb.sv
// ============================================================================
// Module      : biriscv_csr_wb
// Description : Writeback-side partner of the CSR issue/E1 unit. It carries
//               each CSR-class instruction through E1 -> E2 -> WB, merges late
//               memory faults and interrupt injection on the E2->WB advance,
//               commits CSR writes / exceptions on the csr_writeback bus and
//               returns the CSR read value to the integer register file.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SUPPORT_SUPER  1 = page-fault codes (12/13/15) from memory are accepted,
//                  0 = those codes are treated as "no fault".
// Optional feature
//   BIRISCV_CSR_WB_PERF_EN : adds perf_retired_o / perf_exceptions_o counters.
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   issue_*                       issued instruction (valid/opcode/pc/rd)
//   csr_result_e1_*               E1 results, valid the cycle after issue
//   mem_exception_e2_i / mem_fault_addr_e2_i  late fault for the E2 instr
//   stall_i, squash_e1_i          pipeline hold, kill of E1
//   take_interrupt_i              interrupt request from the CSR unit
//   csr_wb (master)               csr_writeback_* commit bus
//   rd_wb_valid_o/idx_o/value_o   integer register file write
//   interrupt_inhibit_o           any stage valid
// ============================================================================
`default_nettype none

module biriscv_csr_wb #(
  parameter int SUPPORT_SUPER = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        issue_valid_i,
  input  logic [31:0] issue_opcode_i,
  input  logic [31:0] issue_pc_i,
  input  logic [4:0]  issue_rd_idx_i,
  input  logic [31:0] csr_result_e1_value_i,
  input  logic        csr_result_e1_write_i,
  input  logic [31:0] csr_result_e1_wdata_i,
  input  logic [5:0]  csr_result_e1_exception_i,
  input  logic [5:0]  mem_exception_e2_i,
  input  logic [31:0] mem_fault_addr_e2_i,
  input  logic        stall_i,
  input  logic        squash_e1_i,
  input  logic        take_interrupt_i,
  biriscv_csr_wb_if.master csr_wb,
  output logic        rd_wb_valid_o,
  output logic [4:0]  rd_wb_idx_o,
  output logic [31:0] rd_wb_value_o,
`ifdef BIRISCV_CSR_WB_PERF_EN
  output logic [31:0] perf_retired_o,
  output logic [31:0] perf_exceptions_o,
`endif
  output logic        interrupt_inhibit_o
);

  localparam logic [5:0] EXCEPTION_NONE      = 6'h00;
  localparam logic [5:0] EXCEPTION_INTERRUPT = 6'h20;
  localparam logic [5:0] EXCEPTION_FENCE     = 6'h13;
  localparam logic [6:0] OPCODE_SYSTEM       = 7'h73;

  // --------------------------------------------------------------------------
  // Stage registers. Only the opcode fields used downstream are carried:
  // the CSR address and a "CSRRx" flag decoded at issue.
  // --------------------------------------------------------------------------
  logic        r_e1_valid;
  logic [31:0] r_e1_pc;
  logic [11:0] r_e1_csr_addr;
  logic        r_e1_csrrx;
  logic [4:0]  r_e1_rd;

  logic        r_e2_valid;
  logic [31:0] r_e2_pc;
  logic [11:0] r_e2_csr_addr;
  logic        r_e2_csrrx;
  logic [4:0]  r_e2_rd;
  logic [31:0] r_e2_value;
  logic        r_e2_write;
  logic [31:0] r_e2_wdata;
  logic [5:0]  r_e2_exception;

  logic        r_wb_valid;
  logic [31:0] r_wb_pc;
  logic [11:0] r_wb_csr_addr;
  logic        r_wb_csrrx;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_value;
  logic        r_wb_write;
  logic [31:0] r_wb_wdata;
  logic [5:0]  r_wb_exception;
  logic [31:0] r_wb_fault_addr;

  logic        w_issue_csrrx;
  logic        w_unused_opcode_bits;
  logic [5:0]  w_mem_exc;
  logic        w_late_fault;
  logic        w_take_irq;
  logic [5:0]  w_wb_exception;
  logic [31:0] w_wb_fault_addr;
  logic        w_commit;
  logic        w_exc_allows_write;
  logic        w_flush;

  // CSRRW/S/C and their immediate forms: SYSTEM opcode with funct3[1:0] != 0.
  assign w_issue_csrrx = (issue_opcode_i[6:0] == OPCODE_SYSTEM) &&
                         (issue_opcode_i[13:12] != 2'b00);
  assign w_unused_opcode_bits = ^{issue_opcode_i[19:14], issue_opcode_i[11:7]};

  // Page faults only exist with supervisor/MMU support; without it they are
  // dropped so a stray code cannot raise an exception the core cannot handle.
  generate
    if (SUPPORT_SUPER != 0) begin : g_super
      assign w_mem_exc = mem_exception_e2_i;
    end else begin : g_no_super
      assign w_mem_exc = ((mem_exception_e2_i == 6'd12) ||
                          (mem_exception_e2_i == 6'd13) ||
                          (mem_exception_e2_i == 6'd15)) ? EXCEPTION_NONE
                                                         : mem_exception_e2_i;
    end
  endgenerate

  // Exception merge on E2->WB: early exception beats a late memory fault,
  // and an interrupt is only injected on an otherwise clean instruction.
  always_comb begin
    w_late_fault    = 1'b0;
    w_take_irq      = 1'b0;
    w_wb_exception  = r_e2_exception;
    w_wb_fault_addr = r_e2_value;
    if ((r_e2_exception == EXCEPTION_NONE) && (w_mem_exc != EXCEPTION_NONE)) begin
      w_late_fault    = 1'b1;
      w_wb_exception  = w_mem_exc;
      w_wb_fault_addr = mem_fault_addr_e2_i;
    end else if (take_interrupt_i && r_e2_valid &&
                 (r_e2_exception == EXCEPTION_NONE)) begin
      w_take_irq     = 1'b1;
      w_wb_exception = EXCEPTION_INTERRUPT;
    end
  end

  assign w_commit = r_wb_valid & ~stall_i;
  // A FENCE-style flush still retires the instruction's own side effects.
  assign w_exc_allows_write = (r_wb_exception == EXCEPTION_NONE) ||
                              (r_wb_exception == EXCEPTION_FENCE);
  // Any committed exception flushes the younger instructions in E1/E2.
  assign w_flush = w_commit & (r_wb_exception != EXCEPTION_NONE);

  // --------------------------------------------------------------------------
  // Pipeline advance
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_e1_valid      <= 1'b0;
      r_e1_pc         <= '0;
      r_e1_csr_addr   <= '0;
      r_e1_csrrx      <= 1'b0;
      r_e1_rd         <= '0;
      r_e2_valid      <= 1'b0;
      r_e2_pc         <= '0;
      r_e2_csr_addr   <= '0;
      r_e2_csrrx      <= 1'b0;
      r_e2_rd         <= '0;
      r_e2_value      <= '0;
      r_e2_write      <= 1'b0;
      r_e2_wdata      <= '0;
      r_e2_exception  <= '0;
      r_wb_valid      <= 1'b0;
      r_wb_pc         <= '0;
      r_wb_csr_addr   <= '0;
      r_wb_csrrx      <= 1'b0;
      r_wb_rd         <= '0;
      r_wb_value      <= '0;
      r_wb_write      <= 1'b0;
      r_wb_wdata      <= '0;
      r_wb_exception  <= '0;
      r_wb_fault_addr <= '0;
    end else if (!stall_i) begin
      r_e1_valid      <= issue_valid_i & ~w_flush;
      r_e1_pc         <= issue_pc_i;
      r_e1_csr_addr   <= issue_opcode_i[31:20];
      r_e1_csrrx      <= w_issue_csrrx;
      r_e1_rd         <= issue_rd_idx_i;

      // E1 results arrive one cycle after issue, i.e. during this advance.
      r_e2_valid      <= r_e1_valid & ~squash_e1_i & ~w_flush;
      r_e2_pc         <= r_e1_pc;
      r_e2_csr_addr   <= r_e1_csr_addr;
      r_e2_csrrx      <= r_e1_csrrx;
      r_e2_rd         <= r_e1_rd;
      r_e2_value      <= csr_result_e1_value_i;
      r_e2_write      <= csr_result_e1_write_i;
      r_e2_wdata      <= csr_result_e1_wdata_i;
      r_e2_exception  <= csr_result_e1_exception_i;

      r_wb_valid      <= r_e2_valid & ~w_flush;
      r_wb_pc         <= r_e2_pc;
      r_wb_csr_addr   <= r_e2_csr_addr;
      r_wb_csrrx      <= r_e2_csrrx;
      r_wb_rd         <= r_e2_rd;
      r_wb_value      <= r_e2_value;
      r_wb_write      <= r_e2_write;
      r_wb_wdata      <= r_e2_wdata;
      r_wb_exception  <= w_wb_exception;
      r_wb_fault_addr <= w_wb_fault_addr;
    end
  end

  // --------------------------------------------------------------------------
  // WB outputs: zero unless the WB instruction commits this cycle.
  // --------------------------------------------------------------------------
  assign csr_wb.csr_writeback_write_o          = w_commit & r_wb_write & w_exc_allows_write;
  assign csr_wb.csr_writeback_waddr_o          = w_commit ? r_wb_csr_addr   : 12'h000;
  assign csr_wb.csr_writeback_wdata_o          = w_commit ? r_wb_wdata      : 32'h0;
  assign csr_wb.csr_writeback_exception_o      = w_commit ? r_wb_exception  : EXCEPTION_NONE;
  assign csr_wb.csr_writeback_exception_pc_o   = w_commit ? r_wb_pc         : 32'h0;
  assign csr_wb.csr_writeback_exception_addr_o = w_commit ? r_wb_fault_addr : 32'h0;

  assign rd_wb_valid_o = w_commit & (r_wb_rd != 5'd0) & w_exc_allows_write & r_wb_csrrx;
  assign rd_wb_idx_o   = w_commit ? r_wb_rd    : 5'd0;
  assign rd_wb_value_o = w_commit ? r_wb_value : 32'h0;

  assign interrupt_inhibit_o = r_e1_valid | r_e2_valid | r_wb_valid;

`ifdef BIRISCV_CSR_WB_PERF_EN
  logic [31:0] r_perf_retired;
  logic [31:0] r_perf_exceptions;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_retired    <= '0;
      r_perf_exceptions <= '0;
    end else if (w_commit) begin
      if (r_wb_exception == EXCEPTION_NONE) begin
        r_perf_retired <= r_perf_retired + 32'd1;
      end else begin
        r_perf_exceptions <= r_perf_exceptions + 32'd1;
      end
    end
  end

  assign perf_retired_o    = r_perf_retired;
  assign perf_exceptions_o = r_perf_exceptions;
`endif

endmodule

`default_nettype wire
